// File: rtl/qupls_branch_split_ctrl_pkg.sv
// Shared types and constants for the fetch-group branch-split stage.
package QuplsPkg;

    localparam int SPLIT_NSLOT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } split_state_t;

    // Index of the lowest set bit, or 0 when the mask is empty.
    function automatic logic [2:0] first_valid(input logic [SPLIT_NSLOT-1:0] v);
        first_valid = 3'd0;
        for (int i = SPLIT_NSLOT - 1; i >= 0; i--) begin
            if (v[i]) first_valid = 3'(i);
        end
    endfunction

endpackage

// File: rtl/qupls_branch_split_ctrl_if.sv
// Fetch-side and issue-side handshake bundle for the branch-split controller.
interface qupls_branch_split_ctrl_if;
    import QuplsPkg::*;

    logic                   flush;
    logic                   in_valid;
    logic [SPLIT_NSLOT-1:0] in_slot_v;
    logic [SPLIT_NSLOT-1:0] in_br_mask;
    logic                   in_ready;
    logic                   stall;
    logic                   out_valid;
    logic                   out_ready;
    logic [SPLIT_NSLOT-1:0] out_slot_sel;
    logic                   out_first;
    logic                   out_last;
    logic [1:0]             out_seq;
    logic [31:0]            perf_groups;
    logic [31:0]            perf_subgroups;

    modport slave (
        input  flush, in_valid, in_slot_v, in_br_mask, out_ready,
        output in_ready, stall, out_valid, out_slot_sel, out_first, out_last,
               out_seq, perf_groups, perf_subgroups
    );

    modport master (
        output flush, in_valid, in_slot_v, in_br_mask, out_ready,
        input  in_ready, stall, out_valid, out_slot_sel, out_first, out_last,
               out_seq, perf_groups, perf_subgroups
    );

endinterface

// File: rtl/qupls_branch_split_ctrl_end_find.sv
// Combinational sub-group boundary finder: from the current slot pointer,
// locate the MAX_BR-th effective branch (or slot 3), and derive the slot
// select mask and whether this sub-group finishes the group.
module qupls_split_end_find
    import QuplsPkg::*;
#(
    parameter int MAX_BR = 1
) (
    input  logic [2:0]             ptr_i,
    input  logic [SPLIT_NSLOT-1:0] br_eff_i,
    input  logic [SPLIT_NSLOT-1:0] grp_v_i,
    output logic [1:0]             end_o,
    output logic [SPLIT_NSLOT-1:0] sel_o,
    output logic                   last_o
);

    logic [2:0]             br_cnt;
    logic                   found;
    logic [SPLIT_NSLOT-1:0] beyond;

    // Walk slots upward from ptr counting branches until the limit is hit.
    always_comb begin
        br_cnt = 3'd0;
        found  = 1'b0;
        end_o  = 2'd3;
        for (int i = 0; i < SPLIT_NSLOT; i++) begin
            if (!found && (3'(i) >= ptr_i) && br_eff_i[i]) begin
                br_cnt = br_cnt + 3'd1;
                if (br_cnt == 3'(MAX_BR)) begin
                    end_o = 2'(i);
                    found = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SPLIT_NSLOT; gi++) begin : g_slot
            assign sel_o[gi]  = grp_v_i[gi] & (3'(gi) >= ptr_i) & (2'(gi) <= end_o);
            assign beyond[gi] = grp_v_i[gi] & (2'(gi) > end_o);
        end
    endgenerate

    assign last_o = ~|beyond;

endmodule

// File: rtl/qupls_branch_split_ctrl.sv
// Branch-split sequencer: accepts a 4-slot fetch group and emits one
// slot-select mask per cycle so that each sub-group carries at most MAX_BR
// branches, each ending its sub-group. Groups may follow back-to-back.
// Optional performance counters: define QUPLS_BRANCH_SPLIT_PERF_EN.
module qupls_branch_split_ctrl
    import QuplsPkg::*;
#(
    parameter int NSLOT  = 4,
    parameter int MAX_BR = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    qupls_branch_split_ctrl_if.slave  bus
);

    generate
        if (NSLOT != SPLIT_NSLOT) begin : g_bad_nslot
            $error("qupls_branch_split_ctrl: NSLOT must be 4");
        end
        if (MAX_BR < 1 || MAX_BR > 4) begin : g_bad_max_br
            $error("qupls_branch_split_ctrl: MAX_BR must be 1..4");
        end
    endgenerate

    split_state_t           state_q, state_d;
    logic [SPLIT_NSLOT-1:0] grp_v_q, grp_v_d;
    logic [SPLIT_NSLOT-1:0] grp_br_q, grp_br_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [1:0]             seq_q, seq_d;

    logic [1:0]             end_slot;
    logic [SPLIT_NSLOT-1:0] sel;
    logic                   last;
    logic                   out_valid_c;
    logic                   in_ready_c;
    logic                   accept;
    logic                   fire_out;

    qupls_split_end_find #(
        .MAX_BR (MAX_BR)
    ) u_end_find (
        .ptr_i    (ptr_q),
        .br_eff_i (grp_br_q & grp_v_q),
        .grp_v_i  (grp_v_q),
        .end_o    (end_slot),
        .sel_o    (sel),
        .last_o   (last)
    );

    // Next-state and handshake decode; flush overrides both handshakes.
    always_comb begin
        state_d  = state_q;
        grp_v_d  = grp_v_q;
        grp_br_d = grp_br_q;
        ptr_d    = ptr_q;
        seq_d    = seq_q;

        out_valid_c = ~rst & (state_q == ISSUE);
        in_ready_c  = ~rst & ~bus.flush &
                      ((state_q == IDLE) | (out_valid_c & bus.out_ready & last));
        fire_out    = out_valid_c & bus.out_ready & ~bus.flush;
        accept      = bus.in_valid & in_ready_c;

        if (bus.flush) begin
            state_d = IDLE;
            ptr_d   = 3'd0;
            seq_d   = 2'd0;
        end else begin
            if (fire_out) begin
                ptr_d = {1'b0, end_slot} + 3'd1;
                seq_d = seq_q + 2'd1;
                if (last) state_d = IDLE;
            end
            // A new group taken in the final sub-group's cycle overrides the advance.
            if (accept) begin
                grp_v_d  = bus.in_slot_v;
                grp_br_d = bus.in_br_mask;
                ptr_d    = first_valid(bus.in_slot_v);
                seq_d    = 2'd0;
                state_d  = (bus.in_slot_v != '0) ? ISSUE : IDLE;
            end
        end
    end

    // Control state and latched group registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grp_v_q  <= '0;
            grp_br_q <= '0;
            ptr_q    <= 3'd0;
            seq_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            grp_v_q  <= grp_v_d;
            grp_br_q <= grp_br_d;
            ptr_q    <= ptr_d;
            seq_q    <= seq_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.stall        = ~in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_slot_sel = out_valid_c ? sel : '0;
    assign bus.out_first    = out_valid_c & (seq_q == 2'd0);
    assign bus.out_last     = out_valid_c & last;
    assign bus.out_seq      = out_valid_c ? seq_q : 2'd0;

`ifdef QUPLS_BRANCH_SPLIT_PERF_EN
    logic [31:0] perf_groups_q;
    logic [31:0] perf_subgroups_q;

    // Free-running event counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_groups_q    <= '0;
            perf_subgroups_q <= '0;
        end else begin
            if (accept)   perf_groups_q    <= perf_groups_q + 32'd1;
            if (fire_out) perf_subgroups_q <= perf_subgroups_q + 32'd1;
        end
    end

    assign bus.perf_groups    = perf_groups_q;
    assign bus.perf_subgroups = perf_subgroups_q;
`else
    assign bus.perf_groups    = 32'd0;
    assign bus.perf_subgroups = 32'd0;
`endif

endmodule
